// File: rtl/rotate_cmd_queue.sv
// FWFT command queue feeding right_rotate; holds {data, rfactor} per entry.
// Ports: s_* producer handshake, m_* head/consumer, count, flush (ROTQ_FLUSH_EN).
module rotate_cmd_queue #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [N-1:0]             s_data,
  input  logic [$clog2(N)-1:0]     s_rfactor,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N-1:0]             m_data,
  output logic [$clog2(N)-1:0]     m_rfactor,
`ifdef ROTQ_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int RW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = N + RW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;
  logic          push, pop, clr;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = s_valid && !full;
  assign pop   = m_ready && !empty;

`ifdef ROTQ_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= {s_data, s_rfactor};
  end

  assign head      = mem_q[rd_ptr_q];
  assign s_ready   = !full;
  assign m_valid   = !empty;
  assign m_data    = empty ? '0 : head[EW-1:RW];
  assign m_rfactor = empty ? '0 : head[RW-1:0];
  assign count     = count_q;

endmodule

// File: tb/tb_rotate_cmd_queue.sv
// Directed self-checking bench for rotate_cmd_queue (N=8, DEPTH=4).
// Define ROTQ_FLUSH_EN to also cover the flush path.
module tb_rotate_cmd_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [2:0] s_rfactor;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] m_rfactor;
  logic [2:0] count;
`ifdef ROTQ_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotate_cmd_queue #(.N(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_rfactor(s_rfactor),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_rfactor(m_rfactor),
`ifdef ROTQ_FLUSH_EN
    .flush(flush),
`endif
    .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotr(input logic [7:0] d,
                                      input logic [2:0] r);
    logic [15:0] t;
    t = {d, d} >> r;
    return t[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic [2:0] r, input logic rdy);
    s_valid   = v;
    s_data    = d;
    s_rfactor = r;
    m_ready   = rdy;
  endtask

  initial begin
    logic [7:0] rot_exp [4];
    rot_exp[0] = 8'b11001010;
    rot_exp[1] = 8'b01100101;
    rot_exp[2] = 8'b10110010;
    rot_exp[3] = 8'b01011001;

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    #12;
    chk("rst_cnt",   32'(count),     0);
    chk("rst_srdy",  32'(s_ready),   1);
    chk("rst_mval",  32'(m_valid),   0);
    chk("rst_mdata", 32'(m_data),    0);
    chk("rst_mrf",   32'(m_rfactor), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with a stalled consumer; head must stay at the first entry.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'b11001010, 3'(i), 1'b0);
      step();
      chk("fill_head_rf", 32'(m_rfactor), 0);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    chk("full_cnt",  32'(count),   4);
    chk("full_srdy", 32'(s_ready), 0);
    chk("full_mval", 32'(m_valid), 1);

    // Offer a request while full and popping: only the pop happens.
    drive(1'b1, 8'hFF, 3'd7, 1'b1);
    chk("ord_rf0",  32'(m_rfactor), 0);
    chk("ord_rot0", 32'(rotr(m_data, m_rfactor)), 32'(rot_exp[0]));
    step();
    chk("refuse_cnt", 32'(count),   3);
    chk("refuse_srdy", 32'(s_ready), 1);
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk("ord_rf",  32'(m_rfactor), i);
      chk("ord_rot", 32'(rotr(m_data, m_rfactor)), 32'(rot_exp[i]));
      step();
    end
    chk("drain_cnt",   32'(count),     0);
    chk("drain_mval",  32'(m_valid),   0);
    chk("drain_mdata", 32'(m_data),    0);
    chk("drain_mrf",   32'(m_rfactor), 0);

    // Simultaneous push/pop at count=2.
    drive(1'b1, 8'h11, 3'd1, 1'b0);
    step();
    drive(1'b1, 8'h22, 3'd2, 1'b0);
    step();
    chk("pp_cnt0", 32'(count), 2);
    drive(1'b1, 8'hA5, 3'd5, 1'b1);
    chk("pp_h0", 32'(m_data), 32'h11);
    step();
    chk("pp_cnt1", 32'(count), 2);
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    chk("pp_h1", 32'(m_data), 32'h22);
    step();
    chk("pp_h2",  32'(m_data),    32'hA5);
    chk("pp_rf2", 32'(m_rfactor), 5);
    step();
    chk("pp_cnt2", 32'(count), 0);

    // Ten back-to-back push/pop pairs across the pointer wrap.
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, 8'(8'h30 + i), 3'(i % 8), 1'b1);
      if (i > 0) begin
        chk("wrap_val",  32'(m_valid),   1);
        chk("wrap_data", 32'(m_data),    32'(8'h30 + i - 1));
        chk("wrap_rf",   32'(m_rfactor), 32'((i - 1) % 8));
      end
      step();
      chk("wrap_cnt_le1", 32'(count <= 3'd1), 1);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    chk("wrap_end_cnt", 32'(count), 0);

    // Asynchronous reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h50 + i), 3'd2, 1'b0);
      step();
    end
    chk("mid_cnt3", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt",   32'(count),   0);
    chk("arst_mval",  32'(m_valid), 0);
    chk("arst_srdy",  32'(s_ready), 1);
    chk("arst_mdata", 32'(m_data),  0);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_hold", 32'(count), 0);

`ifdef ROTQ_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h60 + i), 3'd1, 1'b0);
      step();
    end
    chk("fl_cnt3", 32'(count), 3);
    drive(1'b1, 8'h77, 3'd4, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    chk("fl_cnt",   32'(count),   0);
    chk("fl_mval",  32'(m_valid), 0);
    chk("fl_mdata", 32'(m_data),  0);
    step();
    chk("fl_disc", 32'(count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
